// File: rtl/aes_kat_sequencer.sv
// Known-answer-test sequencer for an AES core. It stores DEPTH {plaintext, key,
// expected} vectors. Each vector gets its own core reset pulse, and the core
// output is sampled LATENCY cycles after that reset is released. The block
// reports pass/fail, a saturating mismatch count and the index of the first
// failing vector.
module aes_kat_sequencer #(
    parameter int DATA_W     = 128,
    parameter int KEY_W      = 128,
    parameter int DEPTH      = 16,
    parameter int LATENCY    = 12,
    parameter int RST_CYCLES = 2,
    localparam int IDX_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_pt,
    input  logic [KEY_W-1:0]  wr_key,
    input  logic [DATA_W-1:0] wr_exp,
    input  logic [IDX_W:0]    num_vec,
    input  logic              stop_on_fail,
    input  logic              start,
    output logic              dut_rst,
    output logic [DATA_W-1:0] dut_plaintext,
    output logic [KEY_W-1:0]  dut_key,
    input  logic [DATA_W-1:0] dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [IDX_W:0]    fail_count,
    output logic [IDX_W-1:0]  first_fail_idx,
    output logic              first_fail_valid
);

    localparam int CNT_MAX = (RST_CYCLES > LATENCY) ? RST_CYCLES : LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, RESET, RUN, CHECK} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W:0]      n_q, n_d;
    logic                sof_q, sof_d;
    logic [DATA_W-1:0]   pt_q, pt_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [IDX_W:0]      fcnt_q, fcnt_d;
    logic [IDX_W-1:0]    ffidx_q, ffidx_d;
    logic                ffval_q, ffval_d;

    logic [DATA_W-1:0]   pt_mem  [DEPTH];
    logic [KEY_W-1:0]    key_mem [DEPTH];
    logic [DATA_W-1:0]   exp_mem [DEPTH];

    logic [IDX_W:0]      n_clip;
    logic [IDX_W-1:0]    idx_nxt;
    logic [IDX_W:0]      fcnt_sat;
    logic                last_vec;
    logic                mismatch;

    // Requests beyond the storage depth simply run every stored vector.
    assign n_clip   = (num_vec > (IDX_W+1)'(DEPTH)) ? (IDX_W+1)'(DEPTH) : num_vec;
    assign idx_nxt  = idx_q + 1'b1;
    assign fcnt_sat = (fcnt_q == '1) ? fcnt_q : fcnt_q + 1'b1;
    assign last_vec = ({1'b0, idx_q} == n_q - 1'b1);

    // The core is held in reset everywhere except while it computes and is sampled.
    assign dut_rst          = (state_q == IDLE) || (state_q == RESET);
    assign dut_plaintext    = pt_q;
    assign dut_key          = key_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign fail_count       = fcnt_q;
    assign first_fail_idx   = ffidx_q;
    assign first_fail_valid = ffval_q;

    // Vector storage: not reset, and frozen while a run is using it.
    always_ff @(posedge clk) begin
        if (wr_en && !busy_q) begin
            pt_mem[wr_addr]  <= wr_pt;
            key_mem[wr_addr] <= wr_key;
            exp_mem[wr_addr] <= wr_exp;
        end
    end

    // Sequencer state and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            n_q     <= '0;
            sof_q   <= 1'b0;
            pt_q    <= '0;
            key_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fcnt_q  <= '0;
            ffidx_q <= '0;
            ffval_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            sof_q   <= sof_d;
            pt_q    <= pt_d;
            key_q   <= key_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fcnt_q  <= fcnt_d;
            ffidx_q <= ffidx_d;
            ffval_q <= ffval_d;
        end
    end

    // Next-state logic: reset pulse, compute window, one-cycle compare.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        n_d      = n_q;
        sof_d    = sof_q;
        pt_d     = pt_q;
        key_d    = key_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        fcnt_d   = fcnt_q;
        ffidx_d  = ffidx_q;
        ffval_d  = ffval_q;
        mismatch = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    fcnt_d  = '0;
                    ffval_d = 1'b0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    n_d     = n_clip;
                    sof_d   = stop_on_fail;
                    if (n_clip == '0) begin
                        // An empty run completes immediately and trivially passes.
                        done_d = 1'b1;
                        pass_d = 1'b1;
                    end else begin
                        state_d = RESET;
                        busy_d  = 1'b1;
                        pt_d    = pt_mem[0];
                        key_d   = key_mem[0];
                    end
                end
            end
            RESET: begin
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (cnt_q == CNT_W'(LATENCY - 1)) begin
                    state_d = CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CHECK: begin
                mismatch = (dut_out != exp_mem[idx_q]);
                if (mismatch) begin
                    fcnt_d = fcnt_sat;
                    if (!ffval_q) begin
                        ffidx_d = idx_q;
                        ffval_d = 1'b1;
                    end
                end
                if ((mismatch && sof_q) || last_vec) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (fcnt_d == '0);
                end else begin
                    state_d = RESET;
                    idx_d   = idx_nxt;
                    pt_d    = pt_mem[idx_nxt];
                    key_d   = key_mem[idx_nxt];
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
